// File: rtl/imem_boot.sv
// -----------------------------------------------------------------------------
// imem_boot
//
// Loadable instruction memory for the LEGv8 pipelined core. It holds
// 2^ADDR_W words of N bits. After reset every word is cleared to NOP (0).
// A program can then be streamed in one byte at a time, most significant byte
// of each word first, while the core's fetch stage is held stalled. Fetch
// reads are combinational (REG_OUT=0) or registered with one cycle of latency
// (REG_OUT=1).
//
// Ports
//   clk          sole clock, rising edge
//   reset        synchronous reset, active low (0 = reset)
//   addr         fetch word address
//   q            fetched instruction, 0 whenever fetch_stall=1
//   fetch_stall  1 while the memory is clearing or loading; the core holds PC
//   load_en      level-sensitive program-load request
//   ld_valid     ld_byte carries a program byte
//   ld_byte      program byte
//   ld_ready     byte accepted on an edge where ld_valid & ld_ready
//   done         sticky: a load finished since reset or the last load start
//   ovf          sticky: bytes arrived after the memory was full
//   wcount       words written in the current or last load
// -----------------------------------------------------------------------------
module imem_boot #(
  parameter int N       = 32,
  parameter int ADDR_W  = 6,
  parameter int REG_OUT = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] addr,
  output logic [N-1:0]      q,
  output logic              fetch_stall,
  input  logic              load_en,
  input  logic              ld_valid,
  input  logic [7:0]        ld_byte,
  output logic              ld_ready,
  output logic              done,
  output logic              ovf,
  output logic [ADDR_W:0]   wcount
);

  localparam int BYTES  = N / 8;
  localparam int DEPTH  = 1 << ADDR_W;
  localparam int BCNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;

  typedef enum logic [1:0] {
    S_CLEAR = 2'd0,
    S_RUN   = 2'd1,
    S_LOAD  = 2'd2
  } state_t;

  state_t state_q, state_d;

  // NOTE: the array has no reset; the CLEAR state walks every word to 0 after
  // reset instead, so the memory can map onto plain RAM without a reset port.
  logic [N-1:0] mem [DEPTH];

  logic [ADDR_W-1:0] cptr_q;
  logic [ADDR_W-1:0] wptr_q;
  logic [BCNT_W-1:0] bcnt_q;
  logic [ADDR_W:0]   wcount_q;
  logic [N-1:0]      asm_q;
  logic              done_q;
  logic              ovf_q;

  logic              enter_load;
  logic              accept;
  logic              full;
  logic              last_byte;
  logic [N-1:0]      asm_shift;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [N-1:0]      mem_wdata;

  // Assembly register with the incoming byte appended at the low end. The
  // shift form also covers N=8, where no older bytes are kept.
  assign asm_shift = (asm_q << 8) | N'(ld_byte);
  assign full      = (wcount_q == (ADDR_W+1)'(DEPTH));
  assign last_byte = (bcnt_q == BCNT_W'(BYTES - 1));

  // Next state and combinational outputs.
  // NOTE: every signal gets a default first so no path leaves one unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_d     = state_q;
    fetch_stall = 1'b1;
    ld_ready    = 1'b0;
    mem_we      = 1'b0;
    mem_waddr   = cptr_q;
    mem_wdata   = '0;
    case (state_q)
      S_CLEAR: begin
        mem_we = 1'b1;
        if (cptr_q == '1) state_d = load_en ? S_LOAD : S_RUN;
      end
      S_RUN: begin
        fetch_stall = 1'b0;
        if (load_en) state_d = S_LOAD;
      end
      S_LOAD: begin
        ld_ready = load_en;
        if (!load_en) state_d = S_RUN;
        mem_waddr = wptr_q;
        mem_wdata = asm_shift;
        mem_we    = ld_valid && load_en && !full && last_byte;
      end
      default: state_d = S_CLEAR;
    endcase
  end

  assign accept     = ld_valid && ld_ready;
  assign enter_load = (state_d == S_LOAD) && (state_q != S_LOAD);

  // NOTE: sequential state uses non-blocking assignments so every register
  // sees the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= S_CLEAR;
      cptr_q   <= '0;
      wptr_q   <= '0;
      bcnt_q   <= '0;
      wcount_q <= '0;
      asm_q    <= '0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      // cptr wraps back to 0 on the final clear edge, ready for the next reset.
      if (state_q == S_CLEAR) cptr_q <= cptr_q + ADDR_W'(1);

      if (enter_load) begin
        wptr_q   <= '0;
        bcnt_q   <= '0;
        wcount_q <= '0;
        done_q   <= 1'b0;
        ovf_q    <= 1'b0;
      end else if (state_q == S_LOAD) begin
        if (!load_en) begin
          // Leaving LOAD: any partially assembled word is discarded.
          done_q <= 1'b1;
          bcnt_q <= '0;
        end else if (accept) begin
          if (full) begin
            // Memory full: keep draining, just flag the overflow.
            ovf_q <= 1'b1;
          end else if (last_byte) begin
            wptr_q   <= wptr_q + ADDR_W'(1);
            wcount_q <= wcount_q + (ADDR_W+1)'(1);
            bcnt_q   <= '0;
          end else begin
            asm_q  <= asm_shift;
            bcnt_q <= bcnt_q + BCNT_W'(1);
          end
        end
      end
    end
  end

  // Single write port shared by the clear walk and the loader. Writes are
  // suppressed while reset is asserted so reset always wins over a load.
  always_ff @(posedge clk) begin
    if (reset && mem_we) mem[mem_waddr] <= mem_wdata;
  end

  generate
    if (REG_OUT != 0) begin : g_reg_out
      logic [N-1:0] q_reg;
      // The register loads only when the next state is RUN. On the final
      // CLEAR edge it loads 0, which is what every word holds after the walk,
      // so the read never races the last clear write.
      always_ff @(posedge clk) begin
        if (!reset) begin
          q_reg <= '0;
        end else if (state_d == S_RUN && state_q != S_CLEAR) begin
          q_reg <= mem[addr];
        end else begin
          q_reg <= '0;
        end
      end
      assign q = q_reg;
    end else begin : g_comb_out
      assign q = (state_q == S_RUN) ? mem[addr] : '0;
    end
  endgenerate

  assign done   = done_q;
  assign ovf    = ovf_q;
  assign wcount = wcount_q;

endmodule

// File: tb/tb_imem_boot.sv
// -----------------------------------------------------------------------------
// tb_imem_boot
//
// Drives two imem_boot instances from the same stimulus: one with
// combinational read (REG_OUT=0) and one with registered read (REG_OUT=1).
// Expected memory contents come from a word array updated from the byte
// streams the bench sends: each group of four bytes forms one word, at most
// 64 words are kept, and a trailing partial word is thrown away.
// -----------------------------------------------------------------------------
module tb_imem_boot;

  localparam int N      = 32;
  localparam int ADDR_W = 6;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              reset;
  logic [ADDR_W-1:0] addr;
  logic              load_en;
  logic              ld_valid;
  logic [7:0]        ld_byte;

  logic [N-1:0]      q0, q1;
  logic              fetch_stall0, fetch_stall1;
  logic              ld_ready0, ld_ready1;
  logic              done0, done1;
  logic              ovf0, ovf1;
  logic [ADDR_W:0]   wcount0, wcount1;

  imem_boot #(.N(N), .ADDR_W(ADDR_W), .REG_OUT(0)) u_dut (
    .clk(clk), .reset(reset), .addr(addr), .q(q0), .fetch_stall(fetch_stall0),
    .load_en(load_en), .ld_valid(ld_valid), .ld_byte(ld_byte),
    .ld_ready(ld_ready0), .done(done0), .ovf(ovf0), .wcount(wcount0)
  );

  imem_boot #(.N(N), .ADDR_W(ADDR_W), .REG_OUT(1)) u_dut_reg (
    .clk(clk), .reset(reset), .addr(addr), .q(q1), .fetch_stall(fetch_stall1),
    .load_en(load_en), .ld_valid(ld_valid), .ld_byte(ld_byte),
    .ld_ready(ld_ready1), .done(done1), .ovf(ovf1), .wcount(wcount1)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [N-1:0] model_mem [DEPTH];
  logic [7:0]   prog_q [$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_ctrl(input string tag, input logic stall, input logic dn,
                            input logic ov, input int wc);
    check({tag, "_stall"},     fetch_stall0, stall);
    check({tag, "_stall_reg"}, fetch_stall1, stall);
    check({tag, "_done"},      done0, dn);
    check({tag, "_ovf"},       ovf0, ov);
    check({tag, "_wcount"},    wcount0, wc);
    check({tag, "_done_reg"},  done1, dn);
    check({tag, "_wcount_reg"}, wcount1, wc);
  endtask

  // Release reset and count edges until fetch stops stalling; the bound turns
  // a stuck CLEAR into a failed comparison instead of a hang.
  task automatic wait_clear();
    int cycles = 0;
    do begin
      addr = ADDR_W'($urandom);
      #1;
      check("clear_q", q0, '0);
      tick();
      cycles++;
    end while (fetch_stall0 && cycles < 200);
    check("clear_cycles", cycles, DEPTH);
    for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
  endtask

  // Sweep every address. The combinational copy answers in the same cycle,
  // the registered copy still shows the previous address until the next edge.
  task automatic readback(input string tag);
    for (int a = 0; a < DEPTH; a++) begin
      addr = ADDR_W'(a);
      #1;
      check({tag, "_q"}, q0, model_mem[a]);
      if (a > 0) check({tag, "_qreg_hold"}, q1, model_mem[a-1]);
      tick();
      check({tag, "_qreg"}, q1, model_mem[a]);
    end
  endtask

  // Stream prog_q into both memories with random idle gaps, then drop
  // load_en (sometimes together with a stray ld_valid, which must be ignored).
  task automatic load_prog(input string tag);
    int nbytes, nwords, exp_wc;
    nbytes = prog_q.size();
    nwords = nbytes / 4;
    addr = '0;
    tick();
    check({tag, "_pre_qreg"}, q1, model_mem[0]);
    load_en = 1'b1;
    tick();
    check({tag, "_entry_q"}, q0, '0);
    check({tag, "_entry_qreg"}, q1, '0);
    check_ctrl({tag, "_entry"}, 1'b1, 1'b0, 1'b0, 0);
    for (int i = 0; i < nbytes; i++) begin
      while ($urandom_range(3) == 0) begin
        ld_valid = 1'b0;
        ld_byte  = 8'($urandom);
        tick();
      end
      ld_valid = 1'b1;
      ld_byte  = prog_q[i];
      check({tag, "_ld_ready"}, ld_ready0, 1'b1);
      tick();
    end
    ld_valid = 1'($urandom_range(1));
    ld_byte  = 8'($urandom);
    load_en  = 1'b0;
    #1;
    check({tag, "_exit_ld_ready"}, ld_ready0, 1'b0);
    tick();
    ld_valid = 1'b0;
    for (int w = 0; w < nwords && w < DEPTH; w++)
      model_mem[w] = {prog_q[4*w], prog_q[4*w+1], prog_q[4*w+2], prog_q[4*w+3]};
    exp_wc = (nwords > DEPTH) ? DEPTH : nwords;
    check_ctrl({tag, "_exit"}, 1'b0, 1'b1, (nbytes > 4 * DEPTH), exp_wc);
  endtask

  initial begin
    reset    = 1'b0;
    addr     = '0;
    load_en  = 1'b0;
    ld_valid = 1'b0;
    ld_byte  = '0;

    // Reset state
    repeat (3) tick();
    check_ctrl("reset", 1'b1, 1'b0, 1'b0, 0);
    check("reset_ld_ready", ld_ready0, 1'b0);
    check("reset_q", q0, '0);
    check("reset_qreg", q1, '0);

    reset = 1'b1;
    wait_clear();
    check_ctrl("after_clear", 1'b0, 1'b0, 1'b0, 0);
    readback("clear_rb");

    // Two full words
    prog_q = '{8'hF8, 8'h00, 8'h00, 8'h00, 8'hF8, 8'h00, 8'h80, 8'h01};
    load_prog("prog1");
    check("prog1_word0", model_mem[0], 32'hF800_0000);
    readback("prog1_rb");

    // One word plus a partial word that must be discarded
    prog_q = '{8'hCB, 8'h0E, 8'h01, 8'hCE, 8'hB4, 8'h00};
    load_prog("prog2");
    readback("prog2_rb");

    // 65 words: the last one overflows and is dropped
    prog_q.delete();
    for (int i = 0; i < 4 * (DEPTH + 1); i++) prog_q.push_back(8'($urandom));
    load_prog("ovf");
    readback("ovf_rb");

    // Random-length loads
    for (int r = 0; r < 3; r++) begin
      prog_q.delete();
      for (int i = 0; i < int'($urandom_range(40, 1)); i++)
        prog_q.push_back(8'($urandom));
      load_prog("rand");
      readback("rand_rb");
    end

    // Reset asserted together with the fifth byte of a load
    load_en = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      ld_valid = 1'b1;
      ld_byte  = 8'($urandom);
      tick();
    end
    ld_valid = 1'b1;
    ld_byte  = 8'($urandom);
    reset    = 1'b0;
    tick();
    check("midload_ld_ready", ld_ready0, 1'b0);
    check("midload_stall", fetch_stall0, 1'b1);
    load_en  = 1'b0;
    ld_valid = 1'b0;
    tick();
    reset = 1'b1;
    wait_clear();
    check_ctrl("midload", 1'b0, 1'b0, 1'b0, 0);
    readback("midload_rb");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/imem_boot.md
# imem_boot

Parametrised, loadable instruction memory for the LEGv8 pipelined core. It replaces the fixed instruction ROM with a RAM of 2^ADDR_W words of N bits. After reset the block clears every word to NOP, then accepts a program as a byte stream while the core's fetch stage is stalled. It serves fetch reads with either combinational or registered output, selected by parameter.

## Interface
- N, 32, instruction word width; multiple of 8; BYTES = N/8
- ADDR_W, 6, word-address width; depth = 2^ADDR_W
- REG_OUT, 0, read mode: 0 = combinational q, 1 = registered q with 1-cycle latency
- clk  in  1  sole clock, rising edge
- reset  in  1  synchronous, active-low (0 = reset)
- addr  in  ADDR_W  fetch word address
- q  out  N  fetched instruction
- fetch_stall  out  1  1 while memory is not in RUN; the core holds PC
- load_en  in  1  request program load; level-sensitive
- ld_valid  in  1  ld_byte valid
- ld_byte  in  8  program byte, most significant byte of each word first
- ld_ready  out  1  byte accepted on an edge where ld_valid & ld_ready
- done  out  1  sticky: a load completed since the last reset or load start
- ovf  out  1  sticky: bytes arrived after the memory was full
- wcount  out  ADDR_W+1  words written in the current or last load

## Operation
- States: CLEAR, RUN, LOAD.
- While reset=0: state=CLEAR, cptr=0, wptr=0, bcnt=0, done=0, ovf=0, wcount=0, registered q=0.
- CLEAR: each edge writes 0 (NOP) to mem[cptr] and increments cptr. On the edge that writes word 2^ADDR_W-1, the next state is LOAD if load_en=1, otherwise RUN. load_en has no other effect during CLEAR.
- RUN: q = mem[addr]. No writes. If load_en=1 at an edge, next state is LOAD.
- LOAD entry: wptr=0, bcnt=0, wcount=0, done=0, ovf=0. Memory is not cleared; words beyond the new program keep their old values.
- LOAD: ld_ready = load_en. On an accepted byte, the byte shifts into the low 8 bits of the assembly register and bcnt increments.
- When the accepted byte is byte BYTES-1: mem[wptr] = {assembly[N-9:0], ld_byte}, then wptr increments, wcount increments and bcnt resets to 0.
- When wcount = 2^ADDR_W, further accepted bytes are dropped, ovf is set, and ld_ready stays 1. Bytes are drained, never back-pressured.
- LOAD exit: load_en=0 at an edge gives next state RUN and sets done=1. Any partial word (bcnt≠0) is discarded. ld_valid is ignored in that cycle because ld_ready is 0.
- Outputs:
  - fetch_stall = (state≠RUN).
  - q = 0 whenever fetch_stall=1, regardless of addr.
  - ld_ready = 0 outside LOAD.
- Reset mid-LOAD or mid-CLEAR: the block returns to CLEAR and all memory is re-cleared after release.

## Timing
- Reset release: CLEAR lasts exactly 2^ADDR_W edges with reset=1. fetch_stall falls after the last clear edge, at cycle 2^ADDR_W (64 for the defaults).
- REG_OUT=0: q follows addr in the same cycle.
- REG_OUT=1: q at edge k+1 equals mem[addr sampled at edge k]. The registered q is forced to 0 on any edge where the next state is not RUN.
- Load write latency: the word becomes readable in RUN on the cycle after the LOAD→RUN edge. No read-during-write case exists.
- Throughput: 1 byte per cycle; 1 word per BYTES cycles.
- Simultaneous load_en rise and reset=0: reset wins.
- Simultaneous ld_valid and load_en fall: the byte is not accepted.

## Test plan
- Reset held 3 cycles, then released → fetch_stall=1 for 64 cycles. Then fetch_stall=0 and q=0x00000000 for addr 0..63. done=0, wcount=0.
- Load the 8 bytes F8,00,00,00,F8,00,80,01, then drop load_en → wcount=2, done=1, ovf=0. q=0xF8000000 at addr 0 and 0xF8008001 at addr 1. addr 2 reads 0.
- Load 6 bytes CB,0E,01,CE,B4,00, then drop load_en → wcount=1, addr 0 = 0xCB0E01CE, addr 1 is unchanged (the partial word is discarded).
- Load 65 words (260 bytes) → wcount=64, ovf=1. ld_ready stays 1 throughout. addr 0..63 hold words 0..63 and word 64 is dropped.
- Assert reset=0 in the middle of a load, at byte 5 → ld_ready=0 next cycle and a full CLEAR follows. All reads give 0, done=0, ovf=0.
- REG_OUT=1: in RUN, step addr 0,1,2 → q shows the three words one cycle later each. Assert load_en → q=0 on the next cycle.
